// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute pipeline: default widths and the
// layout of the decoded control bundle.
package pipe_pkg;

    localparam int XLEN_DEF = 64;
    localparam int AW_DEF   = 5;
    localparam int CTRL_W   = 10;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_ALU_OP_LSB = 6;
    localparam int CTRL_ALU_OP_MSB = 9;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       branch;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } ctrl_t;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/wb_bypass.sv
// Operand select: x0 reads as zero, an in-flight write-back wins over the
// (not yet updated) register file value.
module wb_bypass
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic [AW-1:0]   rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic            wb_wr_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (rs == '0) begin
            operand = '0;
        end else if (wb_wr_en && (wb_addr == rs)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// flush/hold handling and a stall-cycle counter.
module id_ex_stage #(
    parameter int XLEN   = pipe_pkg::XLEN_DEF,
    parameter int AW     = pipe_pkg::AW_DEF,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [AW-1:0]     id_rs1_i,
    input  logic [AW-1:0]     id_rs2_i,
    input  logic [AW-1:0]     id_rd_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [XLEN-1:0]   rf_data_a_i,
    input  logic [XLEN-1:0]   rf_data_b_i,
    input  logic              wb_wr_en_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              flush_i,
    input  logic              ex_hold_i,
    output logic              hazard_stall_o,
    output logic              ex_valid_o,
    output logic [AW-1:0]     ex_rs1_o,
    output logic [AW-1:0]     ex_rs2_o,
    output logic [AW-1:0]     ex_rd_o,
    output logic [XLEN-1:0]   ex_data_a_o,
    output logic [XLEN-1:0]   ex_data_b_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    import pipe_pkg::*;

    logic              vld_p1;
    logic [AW-1:0]     rs1_p1, rs2_p1, rd_p1;
    logic [XLEN-1:0]   data_a_p1, data_b_p1, imm_p1, pc_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic              vld_nxt;
    logic [AW-1:0]     rs1_nxt, rs2_nxt, rd_nxt;
    logic [XLEN-1:0]   data_a_nxt, data_b_nxt, imm_nxt, pc_nxt;
    logic [CTRL_W-1:0] ctrl_nxt;
    logic [CNT_W-1:0]  stall_cnt_nxt;

    logic [XLEN-1:0]   cap_a, cap_b, hold_a, hold_b;
    logic              lu;

    wb_bypass #(.XLEN(XLEN), .AW(AW)) u_byp_a (
        .rs(id_rs1_i), .rf_data(rf_data_a_i), .wb_wr_en(wb_wr_en_i),
        .wb_addr(wb_addr_i), .wb_data(wb_data_i), .operand(cap_a)
    );

    wb_bypass #(.XLEN(XLEN), .AW(AW)) u_byp_b (
        .rs(id_rs2_i), .rf_data(rf_data_b_i), .wb_wr_en(wb_wr_en_i),
        .wb_addr(wb_addr_i), .wb_data(wb_data_i), .operand(cap_b)
    );

    // Held operands are refreshed through the same selection; an x0 source
    // always carries zero, so the x0 case leaves it unchanged.
    wb_bypass #(.XLEN(XLEN), .AW(AW)) u_refresh_a (
        .rs(rs1_p1), .rf_data(data_a_p1), .wb_wr_en(wb_wr_en_i),
        .wb_addr(wb_addr_i), .wb_data(wb_data_i), .operand(hold_a)
    );

    wb_bypass #(.XLEN(XLEN), .AW(AW)) u_refresh_b (
        .rs(rs2_p1), .rf_data(data_b_p1), .wb_wr_en(wb_wr_en_i),
        .wb_addr(wb_addr_i), .wb_data(wb_data_i), .operand(hold_b)
    );

    assign lu = id_valid_i & vld_p1 & is_load(ctrl_p1) & (rd_p1 != '0)
              & ((rd_p1 == id_rs1_i) | (rd_p1 == id_rs2_i));

    assign hazard_stall_o = (lu & ~flush_i) | ex_hold_i;

    always_comb begin
        vld_nxt       = vld_p1;
        rs1_nxt       = rs1_p1;
        rs2_nxt       = rs2_p1;
        rd_nxt        = rd_p1;
        data_a_nxt    = data_a_p1;
        data_b_nxt    = data_b_p1;
        imm_nxt       = imm_p1;
        pc_nxt        = pc_p1;
        ctrl_nxt      = ctrl_p1;
        stall_cnt_nxt = stall_cnt_q;
        if (flush_i || (!ex_hold_i && lu)) begin
            vld_nxt    = 1'b0;
            rs1_nxt    = '0;
            rs2_nxt    = '0;
            rd_nxt     = '0;
            data_a_nxt = '0;
            data_b_nxt = '0;
            imm_nxt    = '0;
            pc_nxt     = '0;
            ctrl_nxt   = CTRL_W'(CTRL_NOP);
            if (!flush_i) begin
                stall_cnt_nxt = stall_cnt_q + CNT_W'(1);
            end
        end else if (ex_hold_i) begin
            data_a_nxt = hold_a;
            data_b_nxt = hold_b;
        end else begin
            vld_nxt    = id_valid_i;
            rs1_nxt    = id_rs1_i;
            rs2_nxt    = id_rs2_i;
            rd_nxt     = id_rd_i;
            data_a_nxt = cap_a;
            data_b_nxt = cap_b;
            imm_nxt    = id_imm_i;
            pc_nxt     = id_pc_i;
            ctrl_nxt   = id_valid_i ? id_ctrl_i : CTRL_W'(CTRL_NOP);
        end
    end

    // ID -> EX register boundary
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1      <= 1'b0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
            data_a_p1   <= '0;
            data_b_p1   <= '0;
            imm_p1      <= '0;
            pc_p1       <= '0;
            ctrl_p1     <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_p1      <= vld_nxt;
            rs1_p1      <= rs1_nxt;
            rs2_p1      <= rs2_nxt;
            rd_p1       <= rd_nxt;
            data_a_p1   <= data_a_nxt;
            data_b_p1   <= data_b_nxt;
            imm_p1      <= imm_nxt;
            pc_p1       <= pc_nxt;
            ctrl_p1     <= ctrl_nxt;
            stall_cnt_q <= stall_cnt_nxt;
        end
    end

    assign ex_valid_o  = vld_p1;
    assign ex_rs1_o    = rs1_p1;
    assign ex_rs2_o    = rs2_p1;
    assign ex_rd_o     = rd_p1;
    assign ex_data_a_o = data_a_p1;
    assign ex_data_b_o = data_b_p1;
    assign ex_imm_o    = imm_p1;
    assign ex_pc_o     = pc_p1;
    assign ex_ctrl_o   = ctrl_p1;
    assign stall_cnt_o = stall_cnt_q;

endmodule
